hazard_ctrl: RTL

Pipeline hazard controller for the 6-stage (fetch, decode, operand-read, execute, mem-access, write-back) 16-bit processor. It keeps a 3-slot scoreboard of destination registers in flight (EX, MEM, WB) and drives the control signals that keep the pipeline correct:

- operand forwarding selects for the operand-read stage;
- a one-cycle load-use stall;
- squashing of the three younger stages on a taken branch/jump;
- the PC redirect.

It sits beside the pipeline, between operand-read and execute, and also keeps saturating stall/flush performance counters.

---
 rtl/proc_pkg.sv | 33 +++
 rtl/fwd_select.sv | 33 +++
 rtl/hazard_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared types for the 6-stage processor pipeline control: FSM states, operand
// forwarding selects, the PC register index and the scoreboard slot record.
// Pure declarations; no timing or flow control.
package proc_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_REDIR   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_t;

  // R0 is the program counter; it is never forwarded.
  localparam logic [2:0] REG_PC = 3'd0;

  typedef struct packed {
    logic       valid;
    logic [2:0] rd;
    logic       is_load;
  } slot_t;

  // A slot holds an instruction whose result will land in register r.
  function automatic logic slot_writes(slot_t s, logic [2:0] r);
    return s.valid && (s.rd == r);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Operand source select for one operand-read source register.
// Purely combinational, zero latency.
// No flow control; the caller decides whether the select is consumed.
module fwd_select
  import proc_pkg::*;
(
  input  slot_t      ex_slot,
  input  slot_t      mem_slot,
  input  slot_t      wb_slot,
  input  logic [2:0] src,
  input  logic       use_src,
  output logic [1:0] sel
);

  // Only the EX slot's load flag matters: a load result is not ready out of EX.
  logic unused_load_bits;
  assign unused_load_bits = mem_slot.is_load ^ wb_slot.is_load;

  // Youngest producer wins; unused sources and the PC read the register file.
  always_comb begin
    sel = FWD_RF;
    if (use_src && (src != REG_PC)) begin
      if (slot_writes(ex_slot, src) && !ex_slot.is_load) begin
        sel = FWD_EX;
      end else if (slot_writes(mem_slot, src)) begin
        sel = FWD_MEM;
      end else if (slot_writes(wb_slot, src)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: scoreboard, forwarding, load-use stall, redirect.
// Control outputs are combinational in the same cycle; state/counters registered.
// A load-use holds the front end one cycle; a redirect squashes it for 1+REFILL.
module hazard_ctrl
  import proc_pkg::*;
#(
  parameter int REFILL = 3,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             or_valid,
  input  logic [2:0]       or_ra,
  input  logic [2:0]       or_rb,
  input  logic             or_use_ra,
  input  logic             or_use_rb,
  input  logic [2:0]       or_rd,
  input  logic             or_we,
  input  logic             or_is_load,
  input  logic             ex_redirect,
  input  logic [15:0]      ex_target,
  output logic             stall_fd,
  output logic             bubble_ex,
  output logic             flush_fdo,
  output logic             pc_load,
  output logic [15:0]      pc_target,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int RW = (REFILL > 1) ? $clog2(REFILL) : 1;

  slot_t            ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  state_t           state_q, state_d;
  logic [RW-1:0]    refill_q, refill_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             load_use, redir_take;

  fwd_select u_fwd_a (
    .ex_slot (ex_q),
    .mem_slot(mem_q),
    .wb_slot (wb_q),
    .src     (or_ra),
    .use_src (or_use_ra),
    .sel     (fwd_a)
  );

  fwd_select u_fwd_b (
    .ex_slot (ex_q),
    .mem_slot(mem_q),
    .wb_slot (wb_q),
    .src     (or_rb),
    .use_src (or_use_rb),
    .sel     (fwd_b)
  );

  // Hazard detection: a load in EX feeding a used source, and a taken redirect.
  always_comb begin
    load_use = or_valid && ex_q.valid && ex_q.is_load &&
               ((or_use_ra && (or_ra != REG_PC) && (or_ra == ex_q.rd)) ||
                (or_use_rb && (or_rb != REG_PC) && (or_rb == ex_q.rd)));
    // EX holds only bubbles during refill, so a redirect there is spurious.
    redir_take = ex_redirect && (state_q != ST_REDIR);
  end

  // Pipeline control; a redirect overrides the stall. Reset masks the input path.
  assign stall_fd  = load_use && !redir_take;
  assign bubble_ex = stall_fd;
  assign flush_fdo = redir_take && !reset;
  assign pc_load   = flush_fdo;
  assign pc_target = reset ? 16'h0000 : ex_target;
  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // Scoreboard advance: EX takes the operand-read instruction unless it is squashed.
  always_comb begin
    ex_d.valid   = or_valid && or_we && !stall_fd && !redir_take;
    ex_d.rd      = or_rd;
    ex_d.is_load = or_is_load;
    mem_d        = ex_q;
    wb_d         = mem_q;
  end

  // Next state and refill countdown.
  always_comb begin
    state_d  = state_q;
    refill_d = refill_q;
    if (redir_take) begin
      state_d  = ST_REDIR;
      refill_d = RW'(REFILL - 1);
    end else begin
      case (state_q)
        ST_RUN:     if (load_use) state_d = ST_LDSTALL;
        ST_LDSTALL: state_d = ST_RUN;
        ST_REDIR: begin
          if (refill_q == '0) state_d = ST_RUN;
          else                refill_d = refill_q - RW'(1);
        end
        default:    state_d = ST_RUN;
      endcase
    end
  end

  // Saturating performance counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_fd && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (((state_q == ST_REDIR) || redir_take) && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // State registers; reset empties the scoreboard and returns to RUN at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      state_q     <= ST_RUN;
      refill_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      state_q     <= state_d;
      refill_q    <= refill_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule
